// File: rtl/multicycle_ctrl_rv32i.sv
// Multi-cycle control FSM for the RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes and a single req/ack memory port, counts retired instructions.
module multicycle_ctrl_rv32i (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  cu_immtype,
    output logic        alu_srcb,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_LOAD, C_STORE, C_OPIMM, C_OP, C_LUI, C_AUIPC,
        C_JAL, C_JALR, C_BRANCH, C_FENCE, C_SYSTEM, C_UNKNOWN
    } op_class_e;

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic        illegal_q, illegal_d;
    logic [31:0] instret_q, instret_d;

    op_class_e   cls;
    logic [2:0]  immtype_c;
    logic        srcb_c;
    logic        mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c;
    logic [1:0]  pc_sel_c, wb_sel_c;

    always_comb begin
        cls       = C_UNKNOWN;
        immtype_c = 3'b000;
        srcb_c    = 1'b0;
        case (opcode)
            7'b0000011: begin cls = C_LOAD;   srcb_c = 1'b1; end
            7'b0100011: begin cls = C_STORE;  immtype_c = 3'b001; srcb_c = 1'b1; end
            7'b0010011: begin cls = C_OPIMM;  srcb_c = 1'b1; end
            7'b0110011: begin cls = C_OP; end
            7'b0110111: begin cls = C_LUI;    immtype_c = 3'b011; end
            7'b0010111: begin cls = C_AUIPC;  immtype_c = 3'b011; srcb_c = 1'b1; end
            7'b1101111: begin cls = C_JAL;    immtype_c = 3'b100; end
            7'b1100111: begin cls = C_JALR;   srcb_c = 1'b1; end
            7'b1100011: begin cls = C_BRANCH; immtype_c = 3'b010; end
            7'b0001111: begin cls = C_FENCE; end
            7'b1110011: begin cls = C_SYSTEM; end
            default:    begin cls = C_UNKNOWN; end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        illegal_d = illegal_q;
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        ir_we_c   = 1'b0;
        pc_we_c   = 1'b0;
        reg_we_c  = 1'b0;
        pc_sel_c  = 2'd0;
        wb_sel_c  = 2'd0;
        case (state_q)
            S_FETCH: begin
                // An issued request is held through run dropping until acknowledged.
                mem_req_c = run | pending_q;
                if (mem_req_c) begin
                    if (mem_ack) begin
                        ir_we_c   = 1'b1;
                        pending_d = 1'b0;
                        state_d   = S_DECODE;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                if (cls == C_SYSTEM) begin
                    state_d = S_HALT;
                end else if (cls == C_UNKNOWN) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls == C_BRANCH) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = branch_taken ? 2'd1 : 2'd0;
                    state_d  = S_FETCH;
                end else if (cls == C_FENCE) begin
                    pc_we_c = 1'b1;
                    state_d = S_FETCH;
                end else if (cls == C_LOAD || cls == C_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (cls == C_STORE);
                if (mem_ack) begin
                    if (cls == C_STORE) begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                pc_we_c  = 1'b1;
                state_d  = S_FETCH;
                case (cls)
                    C_LOAD:  wb_sel_c = 2'd1;
                    C_LUI:   wb_sel_c = 2'd3;
                    C_JAL:   begin wb_sel_c = 2'd2; pc_sel_c = 2'd1; end
                    C_JALR:  begin wb_sel_c = 2'd2; pc_sel_c = 2'd2; end
                    default: wb_sel_c = 2'd0;
                endcase
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        instret_d = instret_q + {31'd0, pc_we_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pending_q <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    // Combinational outputs are gated so nothing fires while reset is held.
    assign mem_req    = rst_n & mem_req_c;
    assign mem_we     = rst_n & mem_we_c;
    assign ir_we      = rst_n & ir_we_c;
    assign pc_we      = rst_n & pc_we_c;
    assign reg_we     = rst_n & reg_we_c;
    assign alu_srcb   = rst_n & srcb_c;
    assign pc_sel     = rst_n ? pc_sel_c  : '0;
    assign wb_sel     = rst_n ? wb_sel_c  : '0;
    assign cu_immtype = rst_n ? immtype_c : '0;
    assign state      = state_q;
    assign illegal    = illegal_q;
    assign instret    = instret_q;

endmodule
